// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: word, RAM state and arbiter FSM encodings.
`default_nettype none

package mem_request_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2,
    HALTED  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_request_arbiter_if.sv
// Datapath-side request/hit bus, RAM-side bus and status, grouped for the arbiter.
`default_nettype none

interface mem_request_arbiter_if #(
  parameter int COUNT_W = 32
);
  import mem_request_arbiter_pkg::*;

  logic               iREN;
  word_t              iaddr;
  logic               dREN;
  logic               dWEN;
  word_t              daddr;
  word_t              dstore;
  logic               halt;
  logic               ihit;
  word_t              iload;
  logic               dhit;
  word_t              dload;
  logic               halted;
  logic               ramREN;
  logic               ramWEN;
  word_t              ramaddr;
  word_t              ramstore;
  word_t              ramload;
  ramstate_t          ramstate;
  logic               err;
  logic               timeout;
  logic [COUNT_W-1:0] icount;
  logic [COUNT_W-1:0] dcount;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt,
    input  ihit, iload, dhit, dload, halted, err, timeout, icount, dcount
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output ihit, iload, dhit, dload, halted, err, timeout, icount, dcount,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

`default_nettype wire

// File: rtl/mem_request_arbiter_wait_timer.sv
// Wait-cycle counter: clears on start, counts while waiting, holds once it reaches LIMIT.
`default_nettype none

module mem_request_arbiter_wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam int            W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0]  LIMIT_C = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

`default_nettype wire

// File: rtl/mem_request_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single-ported RAM, one at a time,
// with halt handling, sticky error/timeout flags and saturating access counters.
`default_nettype none

module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_W        = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  mem_request_arbiter_if.slave  bus
);

  arb_state_t         state_q, state_d;
  word_t              addr_q;
  word_t              data_q;
  logic               wr_q;
  logic               err_q;
  logic               timeout_q;
  logic [COUNT_W-1:0] icount_q;
  logic [COUNT_W-1:0] dcount_q;

  logic w_start;
  logic w_busy;
  logic w_access;
  logic w_wait;
  logic w_expired;
  logic w_ihit;
  logic w_dhit;

  assign w_busy   = (state_q == IFETCH) || (state_q == DACCESS);
  assign w_access = w_busy && (bus.ramstate == ACCESS);
  assign w_wait   = w_busy && ((bus.ramstate == FREE) || (bus.ramstate == BUSY));

  mem_request_arbiter_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .start_i   (w_start),
    .wait_i    (w_wait),
    .expired_o (w_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data requests win over halt, halt wins over fetches; completion always beats halt.
  always_comb begin
    state_d = state_q;
    w_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_d = DACCESS;
          w_start = 1'b1;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.iREN) begin
          state_d = IFETCH;
          w_start = 1'b1;
        end
      end
      IFETCH, DACCESS: begin
        if (bus.ramstate == ACCESS) begin
          state_d = bus.halt ? HALTED : IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    w_ihit     = 1'b0;
    w_dhit     = 1'b0;
    case (state_q)
      IFETCH: begin
        bus.ramREN = 1'b1;
        w_ihit     = w_access;
      end
      DACCESS: begin
        bus.ramREN = !wr_q;
        bus.ramWEN = wr_q;
        w_dhit     = w_access;
      end
      default: ;
    endcase
  end

  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = data_q;
  assign bus.ihit     = w_ihit;
  assign bus.dhit     = w_dhit;
  assign bus.iload    = w_ihit ? bus.ramload : '0;
  assign bus.dload    = w_dhit ? bus.ramload : '0;
  assign bus.halted   = (state_q == HALTED);
  assign bus.err      = err_q;
  assign bus.timeout  = timeout_q;
  assign bus.icount   = icount_q;
  assign bus.dcount   = dcount_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      icount_q  <= '0;
      dcount_q  <= '0;
    end else begin
      if (w_start && (state_d == DACCESS)) begin
        addr_q <= bus.daddr;
        data_q <= bus.dstore;
        wr_q   <= bus.dWEN;
        if (bus.dREN && bus.dWEN) begin
          err_q <= 1'b1;
        end
      end else if (w_start) begin
        addr_q <= bus.iaddr;
        wr_q   <= 1'b0;
      end
      if (w_busy && (bus.ramstate == ERROR)) begin
        err_q <= 1'b1;
      end
      if (w_busy && w_expired) begin
        timeout_q <= 1'b1;
      end
      if (w_ihit && (icount_q != '1)) begin
        icount_q <= icount_q + COUNT_W'(1);
      end
      if (w_dhit && (dcount_q != '1)) begin
        dcount_q <= dcount_q + COUNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter (TIMEOUT_CYCLES=64, 4-bit counters).
`default_nettype none

module tb_mem_request_arbiter;
  import mem_request_arbiter_pkg::*;

  localparam int CW = 4;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  mem_request_arbiter_if #(.COUNT_W(CW)) bus ();

  mem_request_arbiter #(
    .TIMEOUT_CYCLES (64),
    .COUNT_W        (CW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.halt     = 1'b0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    #12;
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_hits",   32'({bus.ihit, bus.dhit}), 32'd0);
    chk("rst_flags",  32'({bus.halted, bus.err, bus.timeout}), 32'd0);
    chk("rst_counts", 32'({bus.icount, bus.dcount}), 32'd0);
    chk("rst_state",  32'(dut.state_q), 32'(IDLE));
    nRST = 1'b1;
    step();

    // T1: reset in the middle of a data write
    bus.dWEN = 1'b1; bus.daddr = 32'h10; bus.dstore = 32'h1; bus.ramstate = BUSY;
    step();
    chk("t1_wen_before", 32'(bus.ramWEN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("t1_wen_async",  32'(bus.ramWEN), 32'd0);
    chk("t1_ren_async",  32'(bus.ramREN), 32'd0);
    chk("t1_state",      32'(dut.state_q), 32'(IDLE));
    chk("t1_dcount",     32'(bus.dcount), 32'd0);
    idle_inputs();
    step();
    nRST = 1'b1;
    step();

    // T2: fetch with two BUSY cycles before ACCESS
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    #1;
    chk("t2_no_early_en", 32'(bus.ramREN), 32'd0);
    step();
    chk("t2_ren",   32'(bus.ramREN), 32'd1);
    chk("t2_addr",  bus.ramaddr, 32'h40);
    chk("t2_busy1", 32'(bus.ihit), 32'd0);
    step();
    chk("t2_busy2", 32'(bus.ihit), 32'd0);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h2408000A;
    #1;
    chk("t2_ihit",  32'(bus.ihit), 32'd1);
    chk("t2_iload", bus.iload, 32'h2408000A);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    chk("t2_ihit_drop", 32'(bus.ihit), 32'd0);
    chk("t2_bubble",    32'(bus.ramREN), 32'd0);
    chk("t2_icount",    32'(bus.icount), 32'd1);

    // T3: simultaneous fetch and write; the write goes first
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
    step();
    chk("t3_wen",   32'(bus.ramWEN), 32'd1);
    chk("t3_ren",   32'(bus.ramREN), 32'd0);
    chk("t3_addr",  bus.ramaddr, 32'h80);
    chk("t3_store", bus.ramstore, 32'hDEADBEEF);
    bus.ramstate = ACCESS;
    #1;
    chk("t3_dhit",  32'({bus.ihit, bus.dhit}), 32'b01);
    step();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    #1;
    chk("t3_dcount", 32'(bus.dcount), 32'd1);
    step();
    chk("t3_fetch_ren",  32'(bus.ramREN), 32'd1);
    chk("t3_fetch_addr", bus.ramaddr, 32'h44);
    bus.ramstate = ACCESS; bus.ramload = 32'h11;
    #1;
    chk("t3_ihit", 32'({bus.ihit, bus.dhit}), 32'b10);
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    chk("t3_icount", 32'(bus.icount), 32'd2);

    // T6a: read and write together -> error, treated as write
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h55;
    step();
    chk("t6_wen", 32'(bus.ramWEN), 32'd1);
    chk("t6_ren", 32'(bus.ramREN), 32'd0);
    chk("t6_err", 32'(bus.err), 32'd1);
    bus.ramstate = ACCESS;
    #1;
    chk("t6_dhit", 32'(bus.dhit), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("t6_dcount", 32'(bus.dcount), 32'd2);
    nRST = 1'b0;
    #1;
    chk("t6_err_cleared", 32'(bus.err), 32'd0);
    step();
    nRST = 1'b1;
    step();

    // T5: long BUSY stretch, then one ERROR cycle, then ACCESS
    bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = BUSY;
    step();
    for (int i = 0; i < 60; i++) step();
    chk("t5_no_timeout_60", 32'(bus.timeout), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t5_timeout_70", 32'(bus.timeout), 32'd1);
    chk("t5_still_waiting", 32'({bus.dhit, bus.ramREN}), 32'b01);
    bus.ramstate = ERROR;
    #1;
    chk("t5_err_nohit", 32'(bus.dhit), 32'd0);
    step();
    chk("t5_err", 32'(bus.err), 32'd1);
    chk("t5_retry", 32'(bus.ramREN), 32'd1);
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE;
    #1;
    chk("t5_dhit",  32'(bus.dhit), 32'd1);
    chk("t5_dload", bus.dload, 32'hCAFE);
    step();
    idle_inputs();
    #1;
    chk("t5_dcount", 32'(bus.dcount), 32'd1);

    // T6b: fetch counter saturates at all-ones
    for (int k = 0; k < 16; k++) begin
      bus.iREN = 1'b1; bus.iaddr = 32'(k * 4);
      step();
      bus.ramstate = ACCESS;
      #1;
      step();
      bus.iREN = 1'b0; bus.ramstate = FREE;
      #1;
      if (k == 14) chk("t6_icount_full", 32'(bus.icount), 32'd15);
    end
    chk("t6_icount_sat", 32'(bus.icount), 32'd15);

    // T4: halt raised during a pending read
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    step();
    bus.halt = 1'b1;
    step();
    chk("t4_not_abandoned", 32'({bus.halted, bus.ramREN}), 32'b01);
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    #1;
    chk("t4_dhit", 32'(bus.dhit), 32'd1);
    step();
    bus.dREN = 1'b0; bus.ramstate = FREE;
    #1;
    chk("t4_halted", 32'(bus.halted), 32'd1);
    chk("t4_state",  32'(dut.state_q), 32'(HALTED));
    chk("t4_dcount", 32'(bus.dcount), 32'd2);
    bus.iREN = 1'b1; bus.ramstate = ACCESS;
    #1;
    chk("t4_no_en", 32'({bus.ramREN, bus.ramWEN, bus.ihit}), 32'd0);
    step();
    step();
    chk("t4_still_no_en", 32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}), 32'd0);
    chk("t4_icount_frozen", 32'(bus.icount), 32'd15);
    chk("t4_halted_hold", 32'(bus.halted), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
